// File: rtl/traffic_request_conditioner_pkg.sv
// Shared definitions for the intersection request front-end.
//  - input counts, lane/street bit indices, default timing parameters
//  - req_t: the registered request set handed to the intersection controller
//  - cnt_w: width of a counter that must hold values 0..n without wrapping
package traffic_request_conditioner_pkg;

  localparam int NUM_PED  = 2;
  localparam int NUM_LANE = 4;

  localparam int STREET_SS = 0;
  localparam int STREET_CS = 1;

  localparam int SS_STRAIGHT = 0;
  localparam int SS_TURN     = 1;
  localparam int CS_STRAIGHT = 2;
  localparam int CS_TURN     = 3;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PRESENCE_CYCLES = 8;

  typedef struct packed {
    logic [NUM_LANE-1:0] car;
    logic [NUM_PED-1:0]  ped;
  } req_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/traffic_request_conditioner_input_debouncer.sv
// input_debouncer: synchronise one raw asynchronous input and debounce it.
//  clk, rst    : system clock, async active-high reset
//  raw_in      : raw asynchronous input
//  db_out      : debounced level
//  rise_pulse  : one-cycle pulse in the cycle after db_out goes 0 -> 1
// The debounced level flips only after the synchronised value has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
module input_debouncer
  import traffic_request_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic db_out,
  output logic rise_pulse
);

  localparam int             CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic          db, db_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw_in;
      s2      <= s1;
      db_prev <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign db_out     = db;
  assign rise_pulse = db & ~db_prev;

endmodule

// File: rtl/traffic_request_conditioner.sv
// traffic_request_conditioner: turns 2 raw pedestrian buttons and 4 raw lane
// car sensors into sticky service requests for the intersection controller.
//  clk, rst                  : system clock, async active-high reset
//  *_pedestrian_button       : raw buttons (straight street, cross street)
//  *_car_sensor              : raw lane sensors (SS straight/turn, CS straight/turn)
//  ped_clear[1:0]            : serve pulses, [0] straight street, [1] cross street
//  lane_clear[3:0]           : serve pulses, [0] SS str, [1] SS turn, [2] CS str, [3] CS turn
//  ped_request / car_request : registered sticky requests, same bit order as clears
//  any_request               : OR of all request bits
// Buttons request on a debounced press edge; sensors request once a car has
// been seen continuously for PRESENCE_CYCLES. Requests persist until cleared.
module traffic_request_conditioner
  import traffic_request_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PRESENCE_CYCLES = DEF_PRESENCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                straight_street_pedestrian_button,
  input  logic                cross_street_pedestrian_button,
  input  logic                straight_street_straight_lane_car_sensor,
  input  logic                straight_street_turn_lane_car_sensor,
  input  logic                cross_street_straight_lane_car_sensor,
  input  logic                cross_street_turn_lane_car_sensor,
  input  logic [NUM_PED-1:0]  ped_clear,
  input  logic [NUM_LANE-1:0] lane_clear,
  output logic [NUM_PED-1:0]  ped_request,
  output logic [NUM_LANE-1:0] car_request,
  output logic                any_request
);

  localparam int             PW        = cnt_w(PRESENCE_CYCLES);
  localparam logic [PW-1:0]  PRES_FULL = PW'(PRESENCE_CYCLES);
  localparam logic [PW-1:0]  PRES_LAST = PW'(PRESENCE_CYCLES - 1);

  logic [NUM_PED-1:0]  ped_raw, ped_rise;
  logic [NUM_LANE-1:0] lane_raw, lane_db;

  // Buttons only care about the press edge, sensors only about the level.
  logic [NUM_PED-1:0]  ped_level_unused;
  logic [NUM_LANE-1:0] lane_rise_unused;

  assign ped_raw[STREET_SS]     = straight_street_pedestrian_button;
  assign ped_raw[STREET_CS]     = cross_street_pedestrian_button;
  assign lane_raw[SS_STRAIGHT]  = straight_street_straight_lane_car_sensor;
  assign lane_raw[SS_TURN]      = straight_street_turn_lane_car_sensor;
  assign lane_raw[CS_STRAIGHT]  = cross_street_straight_lane_car_sensor;
  assign lane_raw[CS_TURN]      = cross_street_turn_lane_car_sensor;

  for (genvar g = 0; g < NUM_PED; g++) begin : g_ped
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (ped_raw[g]),
      .db_out     (ped_level_unused[g]),
      .rise_pulse (ped_rise[g])
    );
  end

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (lane_raw[g]),
      .db_out     (lane_db[g]),
      .rise_pulse (lane_rise_unused[g])
    );
  end

  req_t          req_q;
  logic [PW-1:0] pres_cnt [NUM_LANE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      for (int l = 0; l < NUM_LANE; l++) pres_cnt[l] <= '0;
    end else begin
      // A fresh press beats a simultaneous clear so it is never lost.
      for (int s = 0; s < NUM_PED; s++)
        req_q.ped[s] <= ped_rise[s] | (req_q.ped[s] & ~ped_clear[s]);

      // Clear beats a coincident set and restarts the presence window, so a
      // car still waiting re-requests a full PRESENCE_CYCLES later.
      for (int l = 0; l < NUM_LANE; l++) begin
        if (lane_clear[l]) begin
          pres_cnt[l]  <= '0;
          req_q.car[l] <= 1'b0;
        end else if (!lane_db[l]) begin
          pres_cnt[l]  <= '0;
        end else if (pres_cnt[l] != PRES_FULL) begin
          pres_cnt[l]  <= pres_cnt[l] + PW'(1);
          if (pres_cnt[l] == PRES_LAST) req_q.car[l] <= 1'b1;
        end
      end
    end
  end

  assign ped_request = req_q.ped;
  assign car_request = req_q.car;
  assign any_request = |req_q;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
module tb_traffic_request_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_btn = 1'b0, cs_btn = 1'b0;
  logic       ss_str = 1'b0, ss_turn = 1'b0, cs_str = 1'b0, cs_turn = 1'b0;
  logic [1:0] ped_clear  = '0;
  logic [3:0] lane_clear = '0;
  logic [1:0] ped_request;
  logic [3:0] car_request;
  logic       any_request;

  traffic_request_conditioner dut (
    .clk                                      (clk),
    .rst                                      (rst),
    .straight_street_pedestrian_button        (ss_btn),
    .cross_street_pedestrian_button           (cs_btn),
    .straight_street_straight_lane_car_sensor (ss_str),
    .straight_street_turn_lane_car_sensor     (ss_turn),
    .cross_street_straight_lane_car_sensor    (cs_str),
    .cross_street_turn_lane_car_sensor        (cs_turn),
    .ped_clear                                (ped_clear),
    .lane_clear                               (lane_clear),
    .ped_request                              (ped_request),
    .car_request                              (car_request),
    .any_request                              (any_request)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; sampled on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {any, car[3:0], ped[1:0]}
  logic [6:0] obs;
  assign obs = {any_request, car_request, ped_request};

  localparam logic [6:0] NONE   = 7'b0000000;
  localparam logic [6:0] PED0   = 7'b1000001;
  localparam logic [6:0] PED1   = 7'b1000010;
  localparam logic [6:0] CAR0   = 7'b1000100;
  localparam logic [6:0] CAR3   = 7'b1100000;
  localparam logic [6:0] PEDALL = 7'b1000011;
  localparam logic [6:0] ALL    = 7'b1111111;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    string      tag;
    logic [6:0] val;
  } exp_t;

  exp_t sb[$];

  // Keep the scoreboard ordered by the cycle the value is due.
  task automatic expect_at(input int c, input string tag, input logic [6:0] v);
    exp_t e;
    int   i;
    e.cyc = c; e.tag = tag; e.val = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, 32'(obs), 32'(e.val));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int k, k2;

  initial begin
    #1 chk("reset_state", 32'(obs), 32'(NONE));
    expect_at(2, "reset_hold", NONE);
    tick(3);
    rst = 1'b0;
    tick(2);

    // 1: straight button press, sticky after release, cleared by serve pulse
    k = cyc; ss_btn = 1'b1;
    expect_at(k + 6, "t1_before", NONE);
    expect_at(k + 7, "t1_set", PED0);
    tick(20);
    ss_btn = 1'b0; k = cyc;
    expect_at(k + 10, "t1_sticky", PED0);
    tick(12);
    k = cyc; ped_clear = 2'b01;
    expect_at(k + 1, "t1_clear", NONE);
    tick(1); ped_clear = '0;
    tick(2);

    // 2: 3-cycle glitch ignored, 5-cycle pulse accepted
    k = cyc; cs_btn = 1'b1;
    expect_at(k + 7, "t2_glitch_a", NONE);
    expect_at(k + 10, "t2_glitch_b", NONE);
    tick(3); cs_btn = 1'b0;
    tick(12);
    k = cyc; cs_btn = 1'b1;
    expect_at(k + 6, "t2_pulse_before", NONE);
    expect_at(k + 7, "t2_pulse_set", PED1);
    tick(5); cs_btn = 1'b0;
    tick(12);
    k = cyc; ped_clear = 2'b10;
    expect_at(k + 1, "t2_clear", NONE);
    tick(1); ped_clear = '0;
    tick(2);

    // 3: CS turn presence, survives car leaving, cleared by serve
    k = cyc; cs_turn = 1'b1;
    expect_at(k + 13, "t3_before", NONE);
    expect_at(k + 14, "t3_set", CAR3);
    tick(20); cs_turn = 1'b0;
    expect_at(k + 35, "t3_sticky", CAR3);
    tick(20);
    k = cyc; lane_clear = 4'b1000;
    expect_at(k + 1, "t3_clear", NONE);
    tick(1); lane_clear = '0;
    tick(2);

    // 4: SS straight held; clear while present re-requests 8 edges later;
    //    clear on the would-be set edge wins and restarts the window
    k = cyc; ss_str = 1'b1;
    expect_at(k + 14, "t4_set", CAR0);
    tick(20);
    k = cyc; lane_clear = 4'b0001;
    expect_at(k + 1, "t4_clear", NONE);
    expect_at(k + 8, "t4_rereq_before", NONE);
    expect_at(k + 9, "t4_rereq", CAR0);
    tick(1); lane_clear = '0;
    tick(9);
    k = cyc; lane_clear = 4'b0001;
    expect_at(k + 1, "t4_clear2", NONE);
    tick(1); lane_clear = '0;
    tick(7); lane_clear = 4'b0001;
    expect_at(k + 9, "t4_clear_wins", NONE);
    expect_at(k + 16, "t4_restart_before", NONE);
    expect_at(k + 17, "t4_restart_set", CAR0);
    tick(1); lane_clear = '0;
    tick(17);
    ss_str = 1'b0;
    tick(10);
    k = cyc; lane_clear = 4'b0001;
    expect_at(k + 1, "t4_final_clear", NONE);
    tick(1); lane_clear = '0;
    tick(2);

    // 5: clear coincident with a new debounced press keeps the request
    k = cyc; cs_btn = 1'b1;
    expect_at(k + 7, "t5_first", PED1);
    tick(10); cs_btn = 1'b0;
    tick(12);
    k = cyc; cs_btn = 1'b1;
    tick(6); ped_clear = 2'b10;
    expect_at(k + 7, "t5_set_vs_clear", PED1);
    expect_at(k + 8, "t5_held", PED1);
    tick(1); ped_clear = '0;
    tick(4); cs_btn = 1'b0;
    tick(12);
    k = cyc; ped_clear = 2'b10;
    expect_at(k + 1, "t5_clear", NONE);
    tick(1); ped_clear = '0;
    tick(2);

    // 6: async reset mid-activity, restart from idle with inputs still high
    k = cyc;
    {ss_btn, cs_btn, ss_str, ss_turn, cs_str, cs_turn} = 6'b111111;
    expect_at(k + 7, "t6_ped", PEDALL);
    expect_at(k + 10, "t6_pre_rst", PEDALL);
    tick(10);
    @(posedge clk); #2;
    rst = 1'b1;
    #1 chk("t6_async_rst", 32'(obs), 32'(NONE));
    expect_at(cyc + 1, "t6_rst_hold", NONE);
    tick(3);
    k2 = cyc; rst = 1'b0;
    expect_at(k2 + 6, "t6_ped_before", NONE);
    expect_at(k2 + 7, "t6_ped_after", PEDALL);
    expect_at(k2 + 13, "t6_car_before", PEDALL);
    expect_at(k2 + 14, "t6_car_after", ALL);
    tick(20);
    {ss_btn, cs_btn, ss_str, ss_turn, cs_str, cs_turn} = 6'b000000;
    tick(2);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
